// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encodings and sizing helpers.
package serial_adder_pkg;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Number of digit cycles per operation.
    function automatic int unsigned calc_n(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // Digit counter width: clog2(N), never less than one bit.
    function automatic int unsigned calc_cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fa_digit.sv
// DIGIT-wide ripple of full-adder cells; the single arithmetic slice of the serial adder.
module fa_digit #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = w_c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder processing DIGIT bits per clock, LSB digit first, with start/busy/done handshake.
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned N     = calc_n(WIDTH, DIGIT);
    localparam int unsigned CNT_W = calc_cnt_w(N);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    logic [0:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_a, r_b, r_acc;
    logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_acc_nxt;
    logic             r_carry, w_carry_nxt;
    logic             w_busy_nxt, w_done_nxt, w_cout_nxt;
    logic [WIDTH-1:0] w_sum_nxt;
    logic [DIGIT-1:0] w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_b_cap;
    logic             w_c_cap;
    logic [WIDTH-1:0] w_acc_shift;

    // Subtraction is a + ~b + ~cin, folded into the operand capture.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_cap = sub ? ~b : b;
    assign w_c_cap = sub ? ~cin : cin;
`else
    assign w_b_cap = b;
    assign w_c_cap = cin;
`endif

    fa_digit #(.DIGIT(DIGIT)) u_fa (
        .a  (r_a[DIGIT-1:0]),
        .b  (r_b[DIGIT-1:0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // New digit enters at the MSB end so the last digit lands the word in place.
    assign w_acc_shift = (r_acc >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_acc_nxt   = r_acc;
        w_carry_nxt = r_carry;
        w_busy_nxt  = busy;
        w_done_nxt  = 1'b0;
        w_sum_nxt   = sum;
        w_cout_nxt  = cout;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_nxt     = a;
                    w_b_nxt     = w_b_cap;
                    w_carry_nxt = w_c_cap;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                w_a_nxt     = r_a >> DIGIT;
                w_b_nxt     = r_b >> DIGIT;
                w_acc_nxt   = w_acc_shift;
                w_carry_nxt = w_co;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(N - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_sum_nxt   = w_acc_shift;
                    w_cout_nxt  = w_co;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_acc   <= w_acc_nxt;
            r_carry <= w_carry_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
            sum     <= w_sum_nxt;
            cout    <= w_cout_nxt;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: four configurations against a transaction-level model.
module tb_serial_adder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, start_b, cin_a, cin_b;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif

    logic       busy0, busy1, busy2, busy3, done0, done1, done2, done3;
    logic       cout0, cout1, cout2, cout3;
    logic [7:0] sum0, sum1;
    logic [3:0] sum2, sum3;

    int checks = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d0 (
        .clk(clk), .rst(rst), .start(start_a), .a(a8), .b(b8), .cin(cin_a),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d1 (
        .clk(clk), .rst(rst), .start(start_a), .a(a8), .b(b8), .cin(cin_a),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));
    serial_adder #(.WIDTH(4), .DIGIT(1)) u_d2 (
        .clk(clk), .rst(rst), .start(start_b), .a(a4), .b(b4), .cin(cin_b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2));
    serial_adder #(.WIDTH(4), .DIGIT(2)) u_d3 (
        .clk(clk), .rst(rst), .start(start_b), .a(a4), .b(b4), .cin(cin_b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3));

    logic       dv_busy [4];
    logic       dv_done [4];
    logic       dv_cout [4];
    logic [7:0] dv_sum  [4];
    assign dv_busy = '{busy0, busy1, busy2, busy3};
    assign dv_done = '{done0, done1, done2, done3};
    assign dv_cout = '{cout0, cout1, cout2, cout3};
    assign dv_sum  = '{sum0, sum1, {4'h0, sum2}, {4'h0, sum3}};

    function automatic int unsigned width_of(input int d);
        return (d < 2) ? 8 : 4;
    endfunction
    function automatic int unsigned n_of(input int d);
        case (d)
            0: return 8;
            1: return 2;
            2: return 4;
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0h exp=%0h at t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted op completes N edges later with plain-integer arithmetic.
    int unsigned m_cnt   [4];
    logic [7:0]  m_sum   [4];
    logic [7:0]  m_rsum  [4];
    logic        m_cout  [4];
    logic        m_rcout [4];
    logic        m_done  [4];
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < 4; d++) begin
            int unsigned w, mask, x, y, c;
            bit st, sv;
            int r;
            w    = width_of(d);
            mask = (1 << w) - 1;
            st   = (d < 2) ? start_a : start_b;
            x    = ((d < 2) ? int'(a8) : int'(a4)) & mask;
            y    = ((d < 2) ? int'(b8) : int'(b4)) & mask;
            c    = (d < 2) ? int'(cin_a) : int'(cin_b);
`ifdef SERIAL_ADDER_SUB_EN
            sv   = sub;
`else
            sv   = 1'b0;
`endif
            if (rst) begin
                m_cnt[d]  = 0;
                m_done[d] = 1'b0;
                m_sum[d]  = 8'h00;
                m_cout[d] = 1'b0;
            end else begin
                m_done[d] = 1'b0;
                if (m_cnt[d] != 0) begin
                    m_cnt[d]--;
                    if (m_cnt[d] == 0) begin
                        m_done[d] = 1'b1;
                        m_sum[d]  = m_rsum[d];
                        m_cout[d] = m_rcout[d];
                    end
                end else if (st) begin
                    if (sv) begin
                        r          = int'(x) - int'(y) - int'(c);
                        m_rcout[d] = (r >= 0);
                    end else begin
                        r          = int'(x + y + c);
                        m_rcout[d] = (r > int'(mask));
                    end
                    m_rsum[d] = 8'(r & int'(mask));
                    m_cnt[d]  = n_of(d);
                end
            end
        end
        if (rst) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int d = 0; d < 4; d++) begin
                chk("busy", d, 32'(dv_busy[d]), 32'(m_cnt[d] != 0));
                chk("done", d, 32'(dv_done[d]), 32'(m_done[d]));
                chk("sum",  d, 32'(dv_sum[d]),  32'(m_sum[d]));
                chk("cout", d, 32'(dv_cout[d]), 32'(m_cout[d]));
            end
        end
    end

    task automatic launch_a(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        @(posedge clk); #1;
        a8 = av; b8 = bv; cin_a = cv; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic launch_b(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        @(posedge clk); #1;
        a4 = av; b4 = bv; cin_b = cv; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int d, input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (dv_done[d]) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat, nd, idle;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; cin_a = 1'b0; cin_b = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", 0, 32'(busy0), 32'd0);
        chk("rst_done", 0, 32'(done0), 32'd0);
        chk("rst_sum",  0, 32'(sum0),  32'd0);
        chk("rst_cout", 2, 32'(cout2), 32'd0);

        // FF + 01 ripples a carry through every bit.
        launch_a(8'hFF, 8'h01, 1'b0);
        wait_done(0, 20, lat);
        chk("t1_lat",  0, 32'(lat),   32'd8);
        chk("t1_sum",  0, 32'(sum0),  32'h00);
        chk("t1_cout", 0, 32'(cout0), 32'd1);

        launch_a(8'h35, 8'h4A, 1'b1);
        wait_done(1, 20, lat);
        chk("t2_lat",  1, 32'(lat),   32'd2);
        chk("t2_sum",  1, 32'(sum1),  32'h80);
        chk("t2_cout", 1, 32'(cout1), 32'd0);
        repeat (8) @(posedge clk);

        // A start pulse mid-run must not disturb the running operation.
        launch_a(8'h12, 8'h34, 1'b0);
        repeat (2) @(posedge clk);
        #1 a8 = 8'hAA; b8 = 8'h55; start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done0) begin
                nd++;
                chk("t3_sum", 0, 32'(sum0), 32'h46);
            end
        end
        chk("t3_ndone", 0, 32'(nd), 32'd1);

        // Reset in the middle of a run aborts without a done pulse.
        launch_a(8'h5A, 8'h3C, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("t4_busy", 0, 32'(busy0), 32'd0);
        chk("t4_done", 0, 32'(done0), 32'd0);
        chk("t4_sum",  0, 32'(sum0),  32'd0);
        chk("t4_cout", 0, 32'(cout0), 32'd0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done0) nd++;
        end
        chk("t4_ndone", 0, 32'(nd), 32'd0);

        // Start held through the done cycle gives back-to-back operations.
        @(posedge clk); #1;
        a8 = 8'h10; b8 = 8'h20; cin_a = 1'b0; start_a = 1'b1;
        nd = 0; idle = 0;
        for (int i = 0; i < 40 && nd < 2; i++) begin
            @(posedge clk); #1;
            if (done0) begin
                nd++;
                chk("t5_sum", 0, 32'(sum0), 32'h30);
            end else if (nd == 1 && !busy0) begin
                idle++;
            end
        end
        start_a = 1'b0;
        chk("t5_ndone", 0, 32'(nd),   32'd2);
        chk("t5_idle",  0, 32'(idle), 32'd0);
        repeat (10) @(posedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        #1 sub = 1'b1;
        launch_a(8'h05, 8'h07, 1'b0);
        wait_done(0, 20, lat);
        sub = 1'b0;
        chk("sub_sum",  0, 32'(sum0),  32'hFE);
        chk("sub_cout", 0, 32'(cout0), 32'd0);
        repeat (4) @(posedge clk);
`endif

        // Randomized traffic on the 8-bit pair, including stray starts and rare resets.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            start_a = ($urandom_range(0, 2) == 0);
            a8      = 8'($urandom);
            b8      = 8'($urandom);
            cin_a   = 1'($urandom);
            rst     = ($urandom_range(0, 99) == 0);
        end
        #0 start_a = 1'b0; rst = 1'b0;
        repeat (12) @(posedge clk);

        // Exhaustive 4-bit sweep on both digit sizes.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    launch_b(4'(ia), 4'(ib), 1'(ic));
                    wait_done(2, 10, lat);
                    chk("exh_lat", 2, 32'(lat), 32'd4);
                    chk("exh_d1", 2, 32'({cout2, sum2}), 32'(ia + ib + ic));
                    chk("exh_d2", 3, 32'({cout3, sum3}), 32'(ia + ib + ic));
                end
            end
        end

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
